// File: rtl/cordic_seq_pkg.sv
// cordic_seq_pkg: sequencer state encoding and the angle-range defaults
// shared between the angle sequencer and the CORDIC core.
package cordic_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_ADVANCE = 2'd3
    } seq_state_t;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_N_CH      = 2;
    localparam int DEF_ANGLE_MIN = -74;
    localparam int DEF_ANGLE_MAX = 127;
    localparam int DEF_CH_OFFSET = 32;

    // Number of distinct angles in [amin, amax]
    function automatic int span_of(input int amin, input int amax);
        return amax - amin + 1;
    endfunction

endpackage

// File: rtl/angle_wrap_add.sv
// angle_wrap_add: signed angle plus non-negative increment, wrapped once
// back into [ANGLE_MIN, ANGLE_MAX]. The increment must not exceed the span.
module angle_wrap_add
    import cordic_seq_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ANGLE_MIN = DEF_ANGLE_MIN,
    parameter int ANGLE_MAX = DEF_ANGLE_MAX
)(
    input  logic signed [WIDTH-1:0] a,
    input  logic        [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] sum
);

    localparam logic signed [WIDTH+1:0] MAX_X  = (WIDTH+2)'(ANGLE_MAX);
    localparam logic signed [WIDTH+1:0] SPAN_X = (WIDTH+2)'(span_of(ANGLE_MIN, ANGLE_MAX));

    logic signed [WIDTH+1:0] raw;
    logic signed [WIDTH+1:0] wrapped;

    // Two guard bits keep the sum exact before the single wrap subtraction
    always_comb begin
        raw     = {{2{a[WIDTH-1]}}, a} + {2'b00, b};
        wrapped = raw;
        if (raw > MAX_X) begin
            wrapped = raw - SPAN_X;
        end
        sum = WIDTH'(wrapped);
    end

endmodule

// File: rtl/angle_sweep_seq.sv
// angle_sweep_seq: sweeps a base angle across [ANGLE_MIN, ANGLE_MAX], issues
// one CORDIC op per channel per point and presents all channel results at once.
// Optional CORDIC watchdog: `define DONE_TIMEOUT_EN.
module angle_sweep_seq
    import cordic_seq_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int N_CH        = DEF_N_CH,
    parameter int ANGLE_MIN   = DEF_ANGLE_MIN,
    parameter int ANGLE_MAX   = DEF_ANGLE_MAX,
    parameter int ANGLE_START = 0,
    parameter int CH_OFFSET   = DEF_CH_OFFSET,
`ifdef DONE_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = 255,
`endif
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
)(
    input  logic                    DAC_clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [WIDTH-1:0]        step,
    output logic                    cordic_start,
    output logic signed [WIDTH-1:0] cordic_angle,
    output logic [CH_W-1:0]         cordic_ch,
    input  logic                    cordic_done,
    input  logic signed [WIDTH-1:0] cordic_result,
    output logic [N_CH*WIDTH-1:0]   sample_out,
    output logic                    sample_valid,
    output logic                    timeout_err
);

    localparam logic [WIDTH-1:0] OFFSET  = WIDTH'(CH_OFFSET);
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(N_CH - 1);

    seq_state_t              state;
    logic signed [WIDTH-1:0] base;
    logic signed [WIDTH-1:0] ch_angle;
    logic signed [WIDTH-1:0] next_ch_angle;
    logic signed [WIDTH-1:0] next_base;
    logic [CH_W-1:0]         ch;
    logic [N_CH*WIDTH-1:0]   slots;
    logic [N_CH*WIDTH-1:0]   slots_next;

`ifdef DONE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    // Channel angle advances by one offset per channel instead of base + ch*offset,
    // so a single wrap step stays exact for any channel count.
    angle_wrap_add #(
        .WIDTH     (WIDTH),
        .ANGLE_MIN (ANGLE_MIN),
        .ANGLE_MAX (ANGLE_MAX)
    ) u_ch_wrap (
        .a   (ch_angle),
        .b   (OFFSET),
        .sum (next_ch_angle)
    );

    angle_wrap_add #(
        .WIDTH     (WIDTH),
        .ANGLE_MIN (ANGLE_MIN),
        .ANGLE_MAX (ANGLE_MAX)
    ) u_base_wrap (
        .a   (base),
        .b   (step),
        .sum (next_base)
    );

    // Slot set with the current channel's result merged in
    always_comb begin
        slots_next = slots;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (ch == CH_W'(i)) begin
                slots_next[i*WIDTH +: WIDTH] = cordic_result;
            end
        end
    end

    // Sequencer FSM with registered outputs
    always_ff @(posedge DAC_clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            base         <= WIDTH'(ANGLE_START);
            ch_angle     <= WIDTH'(ANGLE_START);
            ch           <= '0;
            slots        <= '0;
            cordic_start <= 1'b0;
            cordic_angle <= '0;
            cordic_ch    <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
`ifdef DONE_TIMEOUT_EN
            wait_cnt     <= '0;
            timeout_err  <= 1'b0;
`endif
        end else begin
            cordic_start <= 1'b0;
            sample_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state        <= ST_ISSUE;
                        cordic_start <= 1'b1;
                        cordic_angle <= ch_angle;
                        cordic_ch    <= ch;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
`ifdef DONE_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                ST_WAIT: begin
                    if (cordic_done) begin
                        slots <= slots_next;
                        if (ch == LAST_CH) begin
                            state        <= ST_ADVANCE;
                            sample_out   <= slots_next;
                            sample_valid <= 1'b1;
                        end else begin
                            state        <= ST_ISSUE;
                            ch           <= ch + 1'b1;
                            ch_angle     <= next_ch_angle;
                            cordic_start <= 1'b1;
                            cordic_angle <= next_ch_angle;
                            cordic_ch    <= ch + 1'b1;
                        end
                    end
`ifdef DONE_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err  <= 1'b1;
                        state        <= ST_ISSUE;
                        cordic_start <= 1'b1;
                        cordic_angle <= ch_angle;
                        cordic_ch    <= ch;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                ST_ADVANCE: begin
                    state    <= ST_IDLE;
                    base     <= next_base;
                    ch_angle <= next_base;
                    ch       <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_angle_sweep_seq.sv
// tb_angle_sweep_seq: randomized sweep stimulus, CORDIC responder model and a
// scoreboard of expected ops and expected sample words.
module tb_angle_sweep_seq;
    import cordic_seq_pkg::*;

    localparam int WIDTH  = 8;
    localparam int N_CH   = 2;
    localparam int AMIN   = -74;
    localparam int AMAX   = 127;
    localparam int ASTART = 0;
    localparam int OFFS   = 32;
    localparam int SPAN   = AMAX - AMIN + 1;
    localparam int TO     = 16;
`ifdef DONE_TIMEOUT_EN
    localparam int EXP_TO_ERR = 1;
`else
    localparam int EXP_TO_ERR = 0;
`endif

    logic                    DAC_clk = 1'b0;
    logic                    rst;
    logic                    enable;
    logic [WIDTH-1:0]        step;
    logic                    cordic_start;
    logic signed [WIDTH-1:0] cordic_angle;
    logic [0:0]              cordic_ch;
    logic                    cordic_done;
    logic signed [WIDTH-1:0] cordic_result;
    logic [N_CH*WIDTH-1:0]   sample_out;
    logic                    sample_valid;
    logic                    timeout_err;

    angle_sweep_seq #(
        .WIDTH       (WIDTH),
        .N_CH        (N_CH),
        .ANGLE_MIN   (AMIN),
        .ANGLE_MAX   (AMAX),
        .ANGLE_START (ASTART),
`ifdef DONE_TIMEOUT_EN
        .TIMEOUT_CYCLES (TO),
`endif
        .CH_OFFSET   (OFFS)
    ) dut (
        .DAC_clk       (DAC_clk),
        .rst           (rst),
        .enable        (enable),
        .step          (step),
        .cordic_start  (cordic_start),
        .cordic_angle  (cordic_angle),
        .cordic_ch     (cordic_ch),
        .cordic_done   (cordic_done),
        .cordic_result (cordic_result),
        .sample_out    (sample_out),
        .sample_valid  (sample_valid),
        .timeout_err   (timeout_err)
    );

    always #5 DAC_clk = ~DAC_clk;

    typedef struct {
        int angle;
        int ch;
    } op_t;

    op_t                   issue_q[$];
    logic [N_CH*WIDTH-1:0] sample_q[$];

    int checks       = 0;
    int errors       = 0;
    int cyc          = 0;
    int model_base   = ASTART;
    int epoch        = 0;
    int valid_count  = 0;
    int last_valid   = 0;
    int supp_cyc     = -1;
    int fixed_lat    = 0;
    bit gap_pending  = 1'b0;
    bit junk_mode    = 1'b0;
    bit idle_junk    = 1'b0;
    bit suppress     = 1'b0;
    bit rst_d        = 1'b1;
    logic [N_CH*WIDTH-1:0] prev_sample = '0;
    logic [N_CH*WIDTH-1:0] acc = '0;

    always @(posedge DAC_clk) cyc <= cyc + 1;

    function automatic void check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Angle folded into [AMIN, AMAX] by modular arithmetic
    function automatic int wrap_angle(input int a);
        return ((a - AMIN) % SPAN + SPAN) % SPAN + AMIN;
    endfunction

    task automatic push_points(input int n, input int s);
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < N_CH; c++) begin
                issue_q.push_back('{wrap_angle(model_base + c * OFFS), c});
            end
            model_base = wrap_angle(model_base + s);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start"},  longint'(cordic_start), 0);
        check({tag, "_angle"},  longint'(cordic_angle), 0);
        check({tag, "_ch"},     longint'(cordic_ch), 0);
        check({tag, "_sample"}, longint'(sample_out), 0);
        check({tag, "_valid"},  longint'(sample_valid), 0);
        check({tag, "_toerr"},  longint'(timeout_err), 0);
    endtask

    // Runs n sweep points with the given step, releasing enable during the last one
    task automatic run_points(input int n, input int s);
        int target;
        int guard;
        step = WIDTH'(s);
        push_points(n, s);
        target = valid_count + n;
        enable = 1'b1;
        guard  = 0;
        while (valid_count < target - 1 && guard < 400 * n) begin
            @(posedge DAC_clk); #1; guard++;
        end
        guard = 0;
        while (!cordic_start && guard < 100) begin
            @(posedge DAC_clk); #1; guard++;
        end
        enable = 1'b0;
        guard  = 0;
        while (valid_count < target && guard < 400) begin
            @(posedge DAC_clk); #1; guard++;
        end
        check("points_done", valid_count, target);
        repeat (4) @(posedge DAC_clk);
        #1;
    endtask

    // CORDIC responder: checks each issued op, answers after a random latency
    initial begin : responder
        op_t e;
        int lat;
        int my_epoch;
        bit any_start;
        logic signed [WIDTH-1:0] r;
        cordic_done   = 1'b0;
        cordic_result = '0;
        forever begin
            @(negedge DAC_clk);
            cordic_done = 1'b0;
            if (!cordic_start) begin
                if (idle_junk) begin
                    idle_junk     = 1'b0;
                    cordic_done   = 1'b1;
                    cordic_result = 8'sh5A;
                end
                continue;
            end
            if (issue_q.size() == 0) begin
                check("unexpected_start", 1, 0);
                continue;
            end
            e = issue_q.pop_front();
            check("cordic_angle", longint'($signed(cordic_angle)), e.angle);
            check("cordic_ch", longint'(cordic_ch), e.ch);
            if (supp_cyc >= 0) begin
                check("reissue_gap", cyc - supp_cyc, TO + 1);
                check("timeout_err_set", longint'(timeout_err), 1);
                supp_cyc = -1;
            end
            if (suppress) begin
                suppress = 1'b0;
`ifdef DONE_TIMEOUT_EN
                issue_q.push_front(e);
                supp_cyc = cyc;
                continue;
`else
                any_start = 1'b0;
                repeat (40) begin
                    @(negedge DAC_clk);
                    if (cordic_start) any_start = 1'b1;
                end
                check("wait_holds", longint'(any_start), 0);
                check("timeout_err_off", longint'(timeout_err), 0);
`endif
            end
            lat      = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
            r        = WIDTH'($urandom);
            my_epoch = epoch;
            if (junk_mode) begin
                cordic_done   = 1'b1;
                cordic_result = ~r;
            end
            repeat (lat) begin
                @(negedge DAC_clk);
                cordic_done = 1'b0;
            end
            cordic_done   = 1'b1;
            cordic_result = r;
            if (my_epoch == epoch) begin
                acc[e.ch*WIDTH +: WIDTH] = r;
                if (e.ch == N_CH - 1) sample_q.push_back(acc);
            end
        end
    end

    // Sample monitor: scoreboard compare, back-to-back spacing, no silent updates
    initial begin : monitor
        forever begin
            @(negedge DAC_clk);
            if (cordic_start && gap_pending) begin
                check("b2b_gap", cyc - last_valid, 2);
                gap_pending = 1'b0;
            end
            if (sample_valid) begin
                valid_count++;
                if (sample_q.size() == 0) check("unexpected_sample", 1, 0);
                else check("sample_out", longint'(sample_out), longint'(sample_q.pop_front()));
                gap_pending = enable;
                last_valid  = cyc;
            end else if (!rst_d && sample_out !== prev_sample) begin
                check("sample_stable", longint'(sample_out), longint'(prev_sample));
            end
            prev_sample = sample_out;
            rst_d       = rst;
        end
    end

    initial begin : watchdog
        #2000000;
        errors++;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int s;
        rst    = 1'b1;
        enable = 1'b0;
        step   = '0;
        repeat (2) @(posedge DAC_clk);
        @(negedge DAC_clk);
        check_reset_outputs("reset");
        @(posedge DAC_clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge DAC_clk);
        #1;

        // Simple sweep, then exact wrap boundaries
        run_points(3, 1);
        run_points(1, 124);
        run_points(2, 1);
        run_points(1, 193);
        run_points(2, 10);

        // Stray done pulses in IDLE and ISSUE
        idle_junk = 1'b1;
        repeat (5) @(posedge DAC_clk);
        #1;
        junk_mode = 1'b1;
        run_points(2, 7);
        junk_mode = 1'b0;

        // Step extremes and random sweeps
        run_points(2, 0);
        run_points(2, SPAN);
        for (int i = 0; i < 6; i++) begin
            s = int'($urandom_range(0, SPAN));
            run_points(int'($urandom_range(1, 4)), s);
        end

        // Reset while waiting on ch0; the late done must be ignored
        fixed_lat = 8;
        step = WIDTH'(5);
        push_points(1, 5);
        enable = 1'b1;
        for (int g = 0; g < 100 && !cordic_start; g++) begin
            @(posedge DAC_clk); #1;
        end
        enable = 1'b0;
        @(posedge DAC_clk); #1;
        rst = 1'b1;
        @(posedge DAC_clk); #1;
        rst = 1'b0;
        epoch++;
        issue_q.delete();
        model_base = ASTART;
        @(negedge DAC_clk);
        check_reset_outputs("midwait_rst");
        repeat (12) @(posedge DAC_clk);
        #1;
        fixed_lat = 0;
        run_points(2, 3);

        // Suppressed done: watchdog reissue when built in, otherwise indefinite wait
        suppress = 1'b1;
        run_points(1, 2);
        run_points(2, 9);
        check("timeout_err_final", longint'(timeout_err), EXP_TO_ERR);

        check("issue_q_empty", issue_q.size(), 0);
        check("sample_q_empty", sample_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
